// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between the I/D requests of two caches; data beats fetch, round-robin per class.
// Latency: grant drives RAM the cycle after IDLE arbitration; waits drop combinationally on ACCESS.
// Backpressure: a grant is held through FREE/BUSY/ERROR until ACCESS or until the requester withdraws.
module mem_bus_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    output logic                     ramREN,
    output logic                     ramWEN,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    generate
        if (CPUS != 2) begin : g_bad_cpus
            $error("mem_bus_arbiter supports exactly two CPUs");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t          state_q, state_d;
    logic            grant_cpu_q, grant_cpu_d;
    logic            rr_data_q, rr_data_d;
    logic            rr_inst_q, rr_inst_d;
    logic [CPUS-1:0] d_req;

    // Both requesting: the pointer decides; otherwise whoever is asking.
    function automatic logic pick(input logic [CPUS-1:0] req, input logic rr);
        return (&req) ? rr : req[1];
    endfunction

    assign d_req = dREN | dWEN;
    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    always_comb begin
        state_d     = state_q;
        grant_cpu_d = grant_cpu_q;
        rr_data_d   = rr_data_q;
        rr_inst_d   = rr_inst_q;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = '1;
        dwait       = '1;

        case (state_q)
            IDLE: begin
                if (|d_req) begin
                    state_d     = GNT_D;
                    grant_cpu_d = pick(d_req, rr_data_q);
                end else if (|iREN) begin
                    state_d     = GNT_I;
                    grant_cpu_d = pick(iREN, rr_inst_q);
                end
            end
            GNT_D: begin
                if (!d_req[grant_cpu_q]) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = daddr[grant_cpu_q*WORD_W +: WORD_W];
                    if (dWEN[grant_cpu_q]) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore[grant_cpu_q*WORD_W +: WORD_W];
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ramstate == RAM_ACCESS) begin
                        dwait[grant_cpu_q] = 1'b0;
                        state_d            = IDLE;
                        rr_data_d          = ~grant_cpu_q;
                    end
                end
            end
            GNT_I: begin
                if (!iREN[grant_cpu_q]) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[grant_cpu_q*WORD_W +: WORD_W];
                    if (ramstate == RAM_ACCESS) begin
                        iwait[grant_cpu_q] = 1'b0;
                        state_d            = IDLE;
                        rr_inst_d          = ~grant_cpu_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so mask the RAM side and waits while it is held.
        if (!nRST) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
            iwait    = '1;
            dwait    = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            grant_cpu_q <= 1'b0;
            rr_data_q   <= 1'b0;
            rr_inst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_cpu_q <= grant_cpu_d;
            rr_data_q   <= rr_data_d;
            rr_inst_q   <= rr_inst_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: hand-computed expectations checked by immediate assertions.
module tb_mem_bus_arbiter;
    localparam int CPUS = 2;
    localparam int W    = 32;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [1:0]      iREN, dREN, dWEN;
    logic [2*W-1:0]  iaddr, daddr, dstore;
    logic [1:0]      iwait, dwait;
    logic [2*W-1:0]  iload, dload;
    logic [W-1:0]    ramaddr, ramstore, ramload;
    logic            ramREN, ramWEN;
    logic [1:0]      ramstate;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    mem_bus_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ram(input string tag, input logic ren, input logic wen,
                           input logic [W-1:0] addr);
        chk({tag, "_ren"}, {63'd0, ramREN}, {63'd0, ren});
        chk({tag, "_wen"}, {63'd0, ramWEN}, {63'd0, wen});
        chk({tag, "_addr"}, {32'd0, ramaddr}, {32'd0, addr});
    endtask

    task automatic chk_waits(input string tag, input logic [1:0] iw, input logic [1:0] dw);
        chk({tag, "_iwait"}, {62'd0, iwait}, {62'd0, iw});
        chk({tag, "_dwait"}, {62'd0, dwait}, {62'd0, dw});
    endtask

    initial begin
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr  = {32'h0000_0080, 32'h0000_0040};
        daddr  = {32'h0000_0200, 32'h0000_0100};
        dstore = {32'h0000_1234, 32'h0000_5678};
        ramload = 32'h5555_AAAA; ramstate = FREE;

        // reset state
        tick(); tick();
        #1;
        chk_ram("rst", 1'b0, 1'b0, 32'h0);
        chk("rst_store", {32'd0, ramstore}, 64'd0);
        chk_waits("rst", 2'b11, 2'b11);
        chk("rst_iload", iload, {2{32'h5555_AAAA}});
        chk("rst_dload", dload, {2{32'h5555_AAAA}});
        nRST = 1'b1;
        tick();

        // single instruction fetch, BUSY x2 then ACCESS
        iREN = 2'b01; ramstate = BUSY;
        #1 chk_ram("if_idle", 1'b0, 1'b0, 32'h0);
        tick();
        chk_ram("if_c1", 1'b1, 1'b0, 32'h40);
        chk_waits("if_c1", 2'b11, 2'b11);
        tick();
        chk_ram("if_c2", 1'b1, 1'b0, 32'h40);
        chk_waits("if_c2", 2'b11, 2'b11);
        tick();
        ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
        #1;
        chk_waits("if_acc", 2'b10, 2'b11);
        chk("if_iload0", {32'd0, iload[31:0]}, {32'd0, 32'hDEAD_BEEF});
        tick();
        iREN = 2'b00; ramstate = FREE;
        #1;
        chk_ram("if_done", 1'b0, 1'b0, 32'h0);
        chk_waits("if_done", 2'b11, 2'b11);

        // data write beats instruction fetch
        iREN = 2'b01; dWEN = 2'b10;
        tick();
        chk_ram("pri_d", 1'b0, 1'b1, 32'h200);
        chk("pri_store", {32'd0, ramstore}, {32'd0, 32'h1234});
        ramstate = ACCESS;
        #1 chk_waits("pri_d_acc", 2'b11, 2'b01);
        tick();
        dWEN = 2'b00; ramstate = FREE;
        #1 chk_ram("pri_gap", 1'b0, 1'b0, 32'h0);
        tick();
        chk_ram("pri_i", 1'b1, 1'b0, 32'h40);
        ramstate = ACCESS;
        #1 chk_waits("pri_i_acc", 2'b10, 2'b11);
        tick();
        iREN = 2'b00; ramstate = FREE;

        // round-robin on continuous dREN=11 (rr_d is 0 after the CPU1 write)
        dREN = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_ram($sformatf("rr%0d", k), 1'b1, 1'b0, (k % 2 == 0) ? 32'h100 : 32'h200);
            ramstate = ACCESS;
            #1 chk_waits($sformatf("rr%0d_acc", k), 2'b11, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            ramstate = FREE;
            #1 chk_ram($sformatf("rr%0d_gap", k), 1'b0, 1'b0, 32'h0);
        end
        dREN = 2'b00;
        tick();

        // withdrawal while BUSY leaves rr_d at 0
        dREN = 2'b01; ramstate = BUSY;
        tick();
        chk_ram("wd_gnt", 1'b1, 1'b0, 32'h100);
        tick();
        dREN = 2'b00;
        #1;
        chk_ram("wd_drop", 1'b0, 1'b0, 32'h0);
        chk_waits("wd_drop", 2'b11, 2'b11);
        tick();
        chk_ram("wd_idle", 1'b0, 1'b0, 32'h0);
        dREN = 2'b11; ramstate = FREE;
        tick();
        chk_ram("wd_next", 1'b1, 1'b0, 32'h100);
        ramstate = ACCESS;
        #1 chk_waits("wd_next_acc", 2'b11, 2'b10);
        tick();
        dREN = 2'b00; ramstate = FREE;
        tick();

        // ERROR retried three times before ACCESS
        iREN = 2'b10;
        tick();
        ramstate = ERROR;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_ram($sformatf("err%0d", k), 1'b1, 1'b0, 32'h80);
            chk_waits($sformatf("err%0d", k), 2'b11, 2'b11);
            tick();
        end
        ramstate = ACCESS;
        #1 chk_waits("err_acc", 2'b01, 2'b11);
        tick();
        iREN = 2'b00; ramstate = FREE;
        #1 chk_waits("err_done", 2'b11, 2'b11);

        // reset during a CPU1 write grant (rr_d is 1 here); dWEN outranks dREN
        dWEN = 2'b10; dREN = 2'b10;
        tick();
        chk_ram("rm_gnt", 1'b0, 1'b1, 32'h200);
        ramstate = BUSY; nRST = 1'b0;
        #1;
        chk_ram("rm_low", 1'b0, 1'b0, 32'h0);
        chk_waits("rm_low", 2'b11, 2'b11);
        tick();
        chk_ram("rm_edge", 1'b0, 1'b0, 32'h0);
        chk_waits("rm_edge", 2'b11, 2'b11);
        nRST = 1'b1; dWEN = 2'b00; dREN = 2'b11; ramstate = FREE;
        #1 chk_ram("rm_idle", 1'b0, 1'b0, 32'h0);
        tick();
        chk_ram("rm_next", 1'b1, 1'b0, 32'h100);
        ramstate = ACCESS;
        #1 chk_waits("rm_next_acc", 2'b11, 2'b10);
        tick();
        dREN = 2'b00; ramstate = FREE;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
